// File: rtl/reg_bus_arb_if.sv
// Shared register-bus arbiter interface: two requester command/response
// channels plus the register-bus address/strobe/data signals.
//   slave  : arbiter view (takes requests and bus rddata, drives acks, read data and bus)
//   master : requester/bus-model view (drives requests and bus rddata)
interface reg_bus_arb_if;
  logic        m0_req;
  logic        m0_we;
  logic [15:0] m0_addr;
  logic [1:0]  m0_be;
  logic [15:0] m0_wdata;
  logic        m0_ack;
  logic [15:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [15:0] m1_addr;
  logic [1:0]  m1_be;
  logic [15:0] m1_wdata;
  logic        m1_ack;
  logic [15:0] m1_rdata;

  logic [15:0] rdaddr;
  logic [15:0] wraddr;
  logic [1:0]  be;
  logic        write;
  logic [15:0] wrdata;
  logic [15:0] rddata;
  logic [1:0]  grant;
  logic        busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_be, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_be, m1_wdata,
    input  rddata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output rdaddr, wraddr, be, write, wrdata, grant, busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_be, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_be, m1_wdata,
    output rddata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  rdaddr, wraddr, be, write, wrdata, grant, busy
  );
endinterface

// File: rtl/reg_bus_arb.sv
// Two-requester arbiter/sequencer for the shared 16-bit register bus.
// Serialises requester 0 (host) and requester 1 (internal master), drives
// write strobes and read addresses with fixed read latency, and returns
// per-requester read data and a one-cycle ack.
// Ports:
//   clk    : system clock
//   aclr_n : asynchronous reset, active low
//   sclr   : synchronous abort/clear, active high
//   bus    : reg_bus_arb_if.slave (requester channels + register bus)
// Parameters:
//   RD_LAT : cycles from rdaddr first driven to bus rddata valid (1..15)
//   PRIO   : 0 = round-robin, 1 = requester 0 fixed priority
module reg_bus_arb #(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned PRIO   = 0
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic              sclr,
  reg_bus_arb_if.slave      bus
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WR, RD, CPL} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } cmd_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last1;     // 1 = requester 1 was served last
  logic          owner1;    // 1 = requester 1 owns the current access
  logic          write_q;
  logic [AW-1:0] rdaddr_q;
  logic [AW-1:0] wraddr_q;
  logic [BW-1:0] be_q;
  logic [DW-1:0] wrdata_q;
  logic          ack0_q;
  logic          ack1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic [1:0]    grant_q;
  logic          busy_q;

  logic          any_req;
  logic          sel1;
  cmd_t          cmd_win;

  // Winner selection; only consumed in IDLE, so acks never depend on req combinationally.
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    sel1    = bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      sel1 = (PRIO != 0) ? 1'b0 : ~last1;
    end
    cmd_win = sel1 ? cmd_t'{bus.m1_we, bus.m1_addr, bus.m1_be, bus.m1_wdata}
                   : cmd_t'{bus.m0_we, bus.m0_addr, bus.m0_be, bus.m0_wdata};
  end

  // Sequencer with registered bus and response outputs.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last1    <= 1'b1;
      owner1   <= 1'b0;
      write_q  <= 1'b0;
      rdaddr_q <= '0;
      wraddr_q <= '0;
      be_q     <= '0;
      wrdata_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
    end else if (sclr) begin
      // Abort: drop the access silently, keep bus registers and read data.
      state   <= IDLE;
      cnt     <= '0;
      last1   <= 1'b1;
      write_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      write_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner1  <= sel1;
            last1   <= sel1;
            grant_q <= sel1 ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            cnt     <= '0;
            if (cmd_win.we) begin
              state    <= WR;
              write_q  <= 1'b1;
              wraddr_q <= cmd_win.addr;
              be_q     <= cmd_win.be;
              wrdata_q <= cmd_win.wdata;
              ack0_q   <= ~sel1;
              ack1_q   <= sel1;
            end else begin
              state    <= RD;
              rdaddr_q <= cmd_win.addr;
            end
          end
        end
        WR: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        RD: begin
          // cnt runs 0..RD_LAT, giving RD_LAT+1 cycles of rdaddr.
          if (cnt == CW'(RD_LAT)) begin
            state <= CPL;
            cnt   <= '0;
            if (owner1) begin
              rdata1_q <= bus.rddata;
              ack1_q   <= 1'b1;
            end else begin
              rdata0_q <= bus.rddata;
              ack0_q   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CPL: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.write    = write_q;
  assign bus.rdaddr   = rdaddr_q;
  assign bus.wraddr   = wraddr_q;
  assign bus.be       = be_q;
  assign bus.wrdata   = wrdata_q;
  assign bus.m0_ack   = ack0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_reg_bus_arb.sv
// Directed self-checking bench for reg_bus_arb: one round-robin instance and
// one fixed-priority instance share the same requester stimulus.
module tb_reg_bus_arb;

  logic        clk = 1'b0;
  logic        aclr_n;
  logic        sclr;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  m0_be, m1_be;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  reg_bus_arb_if if_rr();
  reg_bus_arb_if if_fp();

  assign if_rr.m0_req = m0_req;   assign if_fp.m0_req = m0_req;
  assign if_rr.m0_we = m0_we;     assign if_fp.m0_we = m0_we;
  assign if_rr.m0_addr = m0_addr; assign if_fp.m0_addr = m0_addr;
  assign if_rr.m0_be = m0_be;     assign if_fp.m0_be = m0_be;
  assign if_rr.m0_wdata = m0_wdata; assign if_fp.m0_wdata = m0_wdata;
  assign if_rr.m1_req = m1_req;   assign if_fp.m1_req = m1_req;
  assign if_rr.m1_we = m1_we;     assign if_fp.m1_we = m1_we;
  assign if_rr.m1_addr = m1_addr; assign if_fp.m1_addr = m1_addr;
  assign if_rr.m1_be = m1_be;     assign if_fp.m1_be = m1_be;
  assign if_rr.m1_wdata = m1_wdata; assign if_fp.m1_wdata = m1_wdata;

  // Bus model: rddata = rdaddr ^ 0x5555, two cycles after rdaddr is driven.
  logic [15:0] rr_d1, rr_rd, fp_d1, fp_rd;
  always_ff @(posedge clk) begin
    rr_d1 <= if_rr.rdaddr ^ 16'h5555;
    rr_rd <= rr_d1;
    fp_d1 <= if_fp.rdaddr ^ 16'h5555;
    fp_rd <= fp_d1;
  end
  assign if_rr.rddata = rr_rd;
  assign if_fp.rddata = fp_rd;

  reg_bus_arb #(.RD_LAT(2), .PRIO(0)) u_rr (.clk(clk), .aclr_n(aclr_n), .sclr(sclr), .bus(if_rr));
  reg_bus_arb #(.RD_LAT(2), .PRIO(1)) u_fp (.clk(clk), .aclr_n(aclr_n), .sclr(sclr), .bus(if_fp));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sclr_pulse();
    sclr = 1'b1;
    step();
    sclr = 1'b0;
  endtask

  task automatic test_reset();
    aclr_n = 1'b0; sclr = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({if_rr.write, if_rr.m0_ack, if_rr.m1_ack, if_rr.busy, if_rr.grant} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
        {if_rr.write, if_rr.m0_ack, if_rr.m1_ack, if_rr.busy, if_rr.grant});
    end
    n_tests++;
    if ({if_rr.rdaddr, if_rr.wraddr, if_rr.wrdata, if_rr.be} !== 50'b0) begin
      n_fail++; $display("FAIL reset_bus: got %h want 0", {if_rr.rdaddr, if_rr.wraddr, if_rr.wrdata, if_rr.be});
    end
    n_tests++;
    if ({if_rr.m0_rdata, if_rr.m1_rdata} !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", {if_rr.m0_rdata, if_rr.m1_rdata});
    end
    aclr_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0185; m0_be = 2'b11; m0_wdata = 16'hA5A5;
    step();
    n_tests++;
    if ({if_rr.write, if_rr.m0_ack, if_rr.m1_ack, if_rr.grant} !== 5'b11001) begin
      n_fail++; $display("FAIL wr_strobe: got %b want 11001", {if_rr.write, if_rr.m0_ack, if_rr.m1_ack, if_rr.grant});
    end
    n_tests++;
    if ({if_rr.wraddr, if_rr.wrdata, if_rr.be} !== {16'h0185, 16'hA5A5, 2'b11}) begin
      n_fail++; $display("FAIL wr_bus: got %h %h %b want 0185 a5a5 11", if_rr.wraddr, if_rr.wrdata, if_rr.be);
    end
    m0_req = 1'b0;
    step();
    n_tests++;
    if ({if_rr.write, if_rr.m0_ack, if_rr.busy, if_rr.grant} !== 5'b0) begin
      n_fail++; $display("FAIL wr_end: got %b want 00000", {if_rr.write, if_rr.m0_ack, if_rr.busy, if_rr.grant});
    end
  endtask

  task automatic test_read();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0104;
    step();
    n_tests++;
    if ({if_rr.grant, if_rr.busy, if_rr.rdaddr} !== {2'b10, 1'b1, 16'h0104}) begin
      n_fail++; $display("FAIL rd_start: got %b %b %h want 10 1 0104", if_rr.grant, if_rr.busy, if_rr.rdaddr);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (if_rr.m1_ack !== 1'b0) begin
        n_fail++; $display("FAIL rd_early_ack: cycle %0d got %b want 0", i + 2, if_rr.m1_ack);
      end
    end
    step();
    n_tests++;
    if ({if_rr.m1_ack, if_rr.m0_ack, if_rr.m1_rdata} !== {2'b10, 16'h5451}) begin
      n_fail++; $display("FAIL rd_ack: got %b %b %h want 1 0 5451", if_rr.m1_ack, if_rr.m0_ack, if_rr.m1_rdata);
    end
    n_tests++;
    if (if_rr.m0_rdata !== 16'h0000) begin
      n_fail++; $display("FAIL rd_other_rdata: got %h want 0000", if_rr.m0_rdata);
    end
    m1_req = 1'b0;
    step();
    n_tests++;
    if ({if_rr.m1_ack, if_rr.busy, if_rr.m1_rdata} !== {2'b00, 16'h5451}) begin
      n_fail++; $display("FAIL rd_hold: got %b %b %h want 0 0 5451", if_rr.m1_ack, if_rr.busy, if_rr.m1_rdata);
    end
  endtask

  task automatic test_back_to_back();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0A0A;
    step();
    n_tests++;
    if (if_rr.rdaddr !== 16'h0A0A) begin
      n_fail++; $display("FAIL b2b_addr1: got %h want 0a0a", if_rr.rdaddr);
    end
    repeat (3) step();
    n_tests++;
    if ({if_rr.m0_ack, if_rr.m0_rdata} !== {1'b1, 16'h5F5F}) begin
      n_fail++; $display("FAIL b2b_ack1: got %b %h want 1 5f5f", if_rr.m0_ack, if_rr.m0_rdata);
    end
    m0_addr = 16'h1234;
    step();
    n_tests++;
    if ({if_rr.busy, if_rr.grant, if_rr.m0_ack, if_rr.rdaddr} !== {4'b0000, 16'h0A0A}) begin
      n_fail++; $display("FAIL b2b_idle: got %b %b %b %h want 0 00 0 0a0a",
        if_rr.busy, if_rr.grant, if_rr.m0_ack, if_rr.rdaddr);
    end
    step();
    n_tests++;
    if ({if_rr.busy, if_rr.grant, if_rr.rdaddr} !== {3'b101, 16'h1234}) begin
      n_fail++; $display("FAIL b2b_start2: got %b %b %h want 1 01 1234", if_rr.busy, if_rr.grant, if_rr.rdaddr);
    end
    repeat (3) step();
    n_tests++;
    if ({if_rr.m0_ack, if_rr.m0_rdata, if_rr.m1_rdata} !== {1'b1, 16'h4761, 16'h5451}) begin
      n_fail++; $display("FAIL b2b_ack2: got %b %h %h want 1 4761 5451", if_rr.m0_ack, if_rr.m0_rdata, if_rr.m1_rdata);
    end
    m0_req = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    logic exp0;
    sclr_pulse();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0010; m0_be = 2'b11; m0_wdata = 16'h1111;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0020; m1_be = 2'b11; m1_wdata = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      exp0 = (k % 2 == 0);
      step();
      n_tests++;
      if ({if_rr.grant, if_rr.m0_ack, if_rr.m1_ack, if_rr.wraddr} !==
          {(exp0 ? 2'b01 : 2'b10), exp0, ~exp0, (exp0 ? 16'h0010 : 16'h0020)}) begin
        n_fail++; $display("FAIL rr_turn%0d: got %b %b %b %h want m%0d", k,
          if_rr.grant, if_rr.m0_ack, if_rr.m1_ack, if_rr.wraddr, exp0 ? 0 : 1);
      end
      step();
      n_tests++;
      if ({if_rr.grant, if_rr.busy} !== 3'b000) begin
        n_fail++; $display("FAIL rr_idle%0d: got %b %b want 00 0", k, if_rr.grant, if_rr.busy);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    sclr_pulse();
  endtask

  task automatic test_fixed_prio();
    logic got;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0030;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0040;
    for (int k = 0; k < 10; k++) begin
      step();
      n_tests++;
      if ({if_fp.m0_ack, if_fp.m1_ack, if_fp.grant} !== 4'b1001) begin
        n_fail++; $display("FAIL fp_m0_%0d: got %b %b %b want 1 0 01", k, if_fp.m0_ack, if_fp.m1_ack, if_fp.grant);
      end
      step();
    end
    m0_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      step();
      if (if_fp.m1_ack === 1'b1) got = 1'b1;
    end
    n_tests++;
    if (got !== 1'b1) begin
      n_fail++; $display("FAIL fp_m1_served: got no m1_ack within 2 cycles, want ack");
    end
    m1_req = 1'b0;
    step();
    sclr_pulse();
  endtask

  task automatic test_abort();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0200;
    step();
    step();
    sclr = 1'b1;
    m0_we = 1'b1; m0_addr = 16'h0300; m0_be = 2'b01; m0_wdata = 16'h1234;
    step();
    sclr = 1'b0;
    n_tests++;
    if ({if_rr.busy, if_rr.grant, if_rr.m0_ack, if_rr.write} !== 5'b0) begin
      n_fail++; $display("FAIL abort_idle: got %b %b %b %b want 0 00 0 0",
        if_rr.busy, if_rr.grant, if_rr.m0_ack, if_rr.write);
    end
    n_tests++;
    if (if_rr.m0_rdata !== 16'h4761) begin
      n_fail++; $display("FAIL abort_rdata_kept: got %h want 4761", if_rr.m0_rdata);
    end
    step();
    n_tests++;
    if ({if_rr.m0_ack, if_rr.write, if_rr.wraddr, if_rr.wrdata, if_rr.be} !== {2'b11, 16'h0300, 16'h1234, 2'b01}) begin
      n_fail++; $display("FAIL abort_next_wr: got %b %b %h %h %b want 1 1 0300 1234 01",
        if_rr.m0_ack, if_rr.write, if_rr.wraddr, if_rr.wrdata, if_rr.be);
    end
    m0_req = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0400; m0_be = 2'b11; m0_wdata = 16'hBEEF;
    step();
    n_tests++;
    if (if_rr.write !== 1'b1) begin
      n_fail++; $display("FAIL aclr_pre_wr: got %b want 1", if_rr.write);
    end
    aclr_n = 1'b0;
    #1;
    n_tests++;
    if ({if_rr.write, if_rr.grant, if_rr.m0_ack, if_rr.busy} !== 5'b0) begin
      n_fail++; $display("FAIL aclr_ctrl: got %b %b %b %b want 0 00 0 0",
        if_rr.write, if_rr.grant, if_rr.m0_ack, if_rr.busy);
    end
    n_tests++;
    if ({if_rr.wraddr, if_rr.m0_rdata} !== 32'h0) begin
      n_fail++; $display("FAIL aclr_regs: got %h %h want 0000 0000", if_rr.wraddr, if_rr.m0_rdata);
    end
    m0_req = 1'b0;
    step();
    aclr_n = 1'b1;
    step();
    n_tests++;
    if ({if_rr.busy, if_rr.write, if_rr.m0_ack} !== 3'b0) begin
      n_fail++; $display("FAIL aclr_after: got %b %b %b want 0 0 0", if_rr.busy, if_rr.write, if_rr.m0_ack);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_round_robin();
    test_fixed_prio();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
